// File: rtl/noc_axi4_txn_gate_pkg.sv
// Shared types and constants for the AXI4 transaction gate between the NoC bridge and the DDR4 controller.
package noc_axi4_txn_gate_pkg;

    typedef enum logic [1:0] {
        ST_CALIB   = 2'd0,
        ST_RUN     = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DRAINED = 2'd3
    } state_e;

    localparam int CNT_W = 8;

    localparam int ERR_UNDERFLOW  = 0;
    localparam int ERR_CALIB_LOST = 1;

endpackage

// File: rtl/noc_axi4_txn_cnt.sv
// Outstanding-burst counter: +1 on request handshake, -1 on completion, with cap compare and underflow flag.
module noc_axi4_txn_cnt
    import noc_axi4_txn_gate_pkg::*;
#(
    parameter int unsigned MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             below_cap_o,
    output logic             underflow_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o       = cnt_q;
    assign below_cap_o = (cnt_q < CNT_W'(MAX));

endmodule

// File: rtl/noc_axi4_txn_gate.sv
// Gates AW/AR address handshakes on calibration and drain state, and caps outstanding reads and writes.
module noc_axi4_txn_gate
    import noc_axi4_txn_gate_pkg::*;
#(
    parameter int unsigned MAX_WR = 16,
    parameter int unsigned MAX_RD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             calib_done,
    input  logic             drain_req,
    output logic             drained,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [1:0]       err,
    input  logic             s_aw_valid,
    output logic             s_aw_ready,
    output logic             m_aw_valid,
    input  logic             m_aw_ready,
    input  logic             s_ar_valid,
    output logic             s_ar_ready,
    output logic             m_ar_valid,
    input  logic             m_ar_ready,
    input  logic             b_valid,
    input  logic             b_ready,
    input  logic             r_valid,
    input  logic             r_ready,
    input  logic             r_last
);

    state_e     state_q, state_d;
    logic [1:0] err_q, err_d;
    logic       aw_ok, ar_ok, aw_hs, ar_hs, b_hs, r_done;
    logic       wr_below, rd_below, wr_uf, rd_uf, calib_lost;

    // Gating depends only on registered state and counts, so there is no valid->ready path.
    assign aw_ok      = (state_q == ST_RUN) && wr_below;
    assign ar_ok      = (state_q == ST_RUN) && rd_below;
    assign m_aw_valid = s_aw_valid && aw_ok;
    assign s_aw_ready = m_aw_ready && aw_ok;
    assign m_ar_valid = s_ar_valid && ar_ok;
    assign s_ar_ready = m_ar_ready && ar_ok;

    assign aw_hs  = m_aw_valid && m_aw_ready;
    assign ar_hs  = m_ar_valid && m_ar_ready;
    assign b_hs   = b_valid && b_ready;
    assign r_done = r_valid && r_ready && r_last;

    noc_axi4_txn_cnt #(.MAX(MAX_WR)) u_wr_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (aw_hs),
        .dec_i       (b_hs),
        .cnt_o       (wr_cnt),
        .below_cap_o (wr_below),
        .underflow_o (wr_uf)
    );

    noc_axi4_txn_cnt #(.MAX(MAX_RD)) u_rd_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc_i       (ar_hs),
        .dec_i       (r_done),
        .cnt_o       (rd_cnt),
        .below_cap_o (rd_below),
        .underflow_o (rd_uf)
    );

    assign calib_lost = (state_q != ST_CALIB) && !calib_done;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_CALIB:   if (calib_done) state_d = drain_req ? ST_DRAIN : ST_RUN;
            ST_RUN:     if (drain_req) state_d = ST_DRAIN;
            ST_DRAIN:   if (wr_cnt == '0 && rd_cnt == '0 && !aw_hs && !ar_hs) state_d = ST_DRAINED;
            ST_DRAINED: if (!drain_req) state_d = ST_RUN;
            default:    state_d = ST_CALIB;
        endcase
        // Losing calibration overrides every other transition.
        if (calib_lost) begin
            state_d                = ST_CALIB;
            err_d[ERR_CALIB_LOST]  = 1'b1;
        end
        if (wr_uf || rd_uf) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CALIB;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign drained = (state_q == ST_DRAINED);
    assign err     = err_q;

endmodule

// File: tb/tb_noc_axi4_txn_gate.sv
// Directed and randomized checks of noc_axi4_txn_gate against a cycle-level behavioural model.
module tb_noc_axi4_txn_gate;

    localparam int MAX_WR = 4;
    localparam int MAX_RD = 3;

    localparam int P_CALIB   = 0;
    localparam int P_RUN     = 1;
    localparam int P_DRAIN   = 2;
    localparam int P_DRAINED = 3;

    logic       clk = 1'b0;
    logic       rst, calib_done, drain_req;
    logic       drained;
    logic [7:0] wr_cnt, rd_cnt;
    logic [1:0] err;
    logic       s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
    logic       s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
    logic       b_valid, b_ready, r_valid, r_ready, r_last;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: outstanding counts, phase and sticky error flags.
    int mw, mr, ph;
    bit me0, me1;

    always #5 clk = ~clk;

    noc_axi4_txn_gate #(.MAX_WR(MAX_WR), .MAX_RD(MAX_RD)) dut (
        .clk        (clk),
        .rst        (rst),
        .calib_done (calib_done),
        .drain_req  (drain_req),
        .drained    (drained),
        .wr_cnt     (wr_cnt),
        .rd_cnt     (rd_cnt),
        .err        (err),
        .s_aw_valid (s_aw_valid),
        .s_aw_ready (s_aw_ready),
        .m_aw_valid (m_aw_valid),
        .m_aw_ready (m_aw_ready),
        .s_ar_valid (s_ar_valid),
        .s_ar_ready (s_ar_ready),
        .m_ar_valid (m_ar_valid),
        .m_ar_ready (m_ar_ready),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_last     (r_last)
    );

    // Advance the model by one cycle from the current inputs, then step the clock.
    task automatic tick();
        bit aw_hs, ar_hs, b_hs, r_done;
        int next_ph;
        aw_hs  = (ph == P_RUN) && (mw < MAX_WR) && s_aw_valid && m_aw_ready;
        ar_hs  = (ph == P_RUN) && (mr < MAX_RD) && s_ar_valid && m_ar_ready;
        b_hs   = b_valid && b_ready;
        r_done = r_valid && r_ready && r_last;
        if (rst) begin
            mw = 0; mr = 0; ph = P_CALIB; me0 = 0; me1 = 0;
        end else begin
            next_ph = ph;
            if (ph != P_CALIB && !calib_done) begin
                next_ph = P_CALIB;
                me1 = 1;
            end else begin
                case (ph)
                    P_CALIB:   if (calib_done) next_ph = drain_req ? P_DRAIN : P_RUN;
                    P_RUN:     if (drain_req) next_ph = P_DRAIN;
                    P_DRAIN:   if (mw == 0 && mr == 0 && !aw_hs && !ar_hs) next_ph = P_DRAINED;
                    P_DRAINED: if (!drain_req) next_ph = P_RUN;
                    default:   next_ph = P_CALIB;
                endcase
            end
            if (mw + int'(aw_hs) - int'(b_hs) < 0) me0 = 1;
            else mw = mw + int'(aw_hs) - int'(b_hs);
            if (mr + int'(ar_hs) - int'(r_done) < 0) me0 = 1;
            else mr = mr + int'(ar_hs) - int'(r_done);
            ph = next_ph;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drain_req  = 0;
        s_aw_valid = 0; m_aw_ready = 0;
        s_ar_valid = 0; m_ar_ready = 0;
        b_valid = 0; b_ready = 0;
        r_valid = 0; r_ready = 0; r_last = 0;
    endtask

    // Reset with calibration already done, leaving the DUT in RUN with empty counters.
    task automatic go_run();
        rst = 1;
        idle_inputs();
        calib_done = 1;
        tick();
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        calib_done = 0;
        idle_inputs();
        s_aw_valid = 1; m_aw_ready = 1; s_ar_valid = 1; m_ar_ready = 1;
        tick();
        tick();
        rst = 0;
        tick();
        n_total++;
        if ({m_aw_valid, s_aw_ready, m_ar_valid, s_ar_ready} !== 4'b0000)
            $display("FAIL reset_handshake: got %b expected 0000", {m_aw_valid, s_aw_ready, m_ar_valid, s_ar_ready});
        else n_pass++;
        n_total++;
        if (wr_cnt !== 8'd0 || rd_cnt !== 8'd0)
            $display("FAIL reset_counts: got wr=%0d rd=%0d expected 0/0", wr_cnt, rd_cnt);
        else n_pass++;
        n_total++;
        if (err !== 2'b00 || drained !== 1'b0)
            $display("FAIL reset_err_drained: got err=%b drained=%b expected 00/0", err, drained);
        else n_pass++;
    endtask

    task automatic test_calib_gate();
        int blocked_bad;
        s_ar_valid = 0;
        s_aw_valid = 1; m_aw_ready = 1;
        blocked_bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (m_aw_valid !== 1'b0 || s_aw_ready !== 1'b0) blocked_bad++;
            tick();
        end
        n_total++;
        if (blocked_bad != 0) $display("FAIL calib_block: got %0d open cycles expected 0", blocked_bad);
        else n_pass++;
        n_total++;
        if (wr_cnt !== 8'd0) $display("FAIL calib_wr_cnt: got %0d expected 0", wr_cnt);
        else n_pass++;
        calib_done = 1;
        #1;
        n_total++;
        if (m_aw_valid !== 1'b0) $display("FAIL calib_same_cycle: got %b expected 0", m_aw_valid);
        else n_pass++;
        tick();
        n_total++;
        if ({m_aw_valid, s_aw_ready} !== 2'b11) $display("FAIL calib_first_aw: got %b expected 11", {m_aw_valid, s_aw_ready});
        else n_pass++;
        tick();
        s_aw_valid = 0;
        n_total++;
        if (wr_cnt !== 8'd1) $display("FAIL calib_first_cnt: got %0d expected 1", wr_cnt);
        else n_pass++;
    endtask

    task automatic test_write_cap();
        int hs;
        go_run();
        s_aw_valid = 1; m_aw_ready = 1;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (m_aw_valid && m_aw_ready) hs++;
            tick();
        end
        n_total++;
        if (hs != MAX_WR || wr_cnt !== 8'(MAX_WR))
            $display("FAIL cap_fill: got hs=%0d wr=%0d expected %0d/%0d", hs, wr_cnt, MAX_WR, MAX_WR);
        else n_pass++;
        b_valid = 1; b_ready = 1;
        #1;
        n_total++;
        if ({m_aw_valid, s_aw_ready} !== 2'b00) $display("FAIL cap_blocked: got %b expected 00", {m_aw_valid, s_aw_ready});
        else n_pass++;
        tick();
        b_valid = 0; b_ready = 0;
        #1;
        n_total++;
        if (wr_cnt !== 8'd3 || {m_aw_valid, s_aw_ready} !== 2'b11)
            $display("FAIL cap_freed: got wr=%0d hs=%b expected 3/11", wr_cnt, {m_aw_valid, s_aw_ready});
        else n_pass++;
        m_aw_ready = 0;
        #1;
        n_total++;
        if ({m_aw_valid, s_aw_ready} !== 2'b10) $display("FAIL ready_gate: got %b expected 10", {m_aw_valid, s_aw_ready});
        else n_pass++;
        m_aw_ready = 1;
        tick();
        s_aw_valid = 0;
        n_total++;
        if (wr_cnt !== 8'd4) $display("FAIL cap_refill: got %0d expected 4", wr_cnt);
        else n_pass++;
    endtask

    task automatic test_read_overlap();
        go_run();
        s_ar_valid = 1; m_ar_ready = 1;
        tick();
        tick();
        n_total++;
        if (rd_cnt !== 8'd2) $display("FAIL rd_two: got %0d expected 2", rd_cnt);
        else n_pass++;
        r_valid = 1; r_ready = 1; r_last = 1;
        #1;
        n_total++;
        if (m_ar_valid !== 1'b1) $display("FAIL rd_overlap_valid: got %b expected 1", m_ar_valid);
        else n_pass++;
        tick();
        n_total++;
        if (rd_cnt !== 8'd2) $display("FAIL rd_overlap: got %0d expected 2", rd_cnt);
        else n_pass++;
        s_ar_valid = 0; r_last = 0;
        repeat (3) tick();
        r_last = 1; r_ready = 0;
        tick();
        n_total++;
        if (rd_cnt !== 8'd2) $display("FAIL rd_nonlast: got %0d expected 2", rd_cnt);
        else n_pass++;
        r_ready = 1;
        tick();
        r_valid = 0; r_ready = 0; r_last = 0;
        n_total++;
        if (rd_cnt !== 8'd1) $display("FAIL rd_complete: got %0d expected 1", rd_cnt);
        else n_pass++;
        s_ar_valid = 1;
        repeat (4) tick();
        #1;
        n_total++;
        if (rd_cnt !== 8'(MAX_RD) || m_ar_valid !== 1'b0)
            $display("FAIL rd_cap: got rd=%0d valid=%b expected %0d/0", rd_cnt, m_ar_valid, MAX_RD);
        else n_pass++;
        s_ar_valid = 0;
    endtask

    task automatic test_drain();
        go_run();
        s_aw_valid = 1; m_aw_ready = 1; s_ar_valid = 1; m_ar_ready = 1;
        tick();
        s_ar_valid = 0;
        tick();
        tick();
        s_aw_valid = 0;
        n_total++;
        if (wr_cnt !== 8'd3 || rd_cnt !== 8'd1)
            $display("FAIL drain_setup: got wr=%0d rd=%0d expected 3/1", wr_cnt, rd_cnt);
        else n_pass++;
        drain_req = 1;
        tick();
        s_aw_valid = 1; s_ar_valid = 1;
        #1;
        n_total++;
        if ({m_aw_valid, s_aw_ready, m_ar_valid, s_ar_ready} !== 4'b0000)
            $display("FAIL drain_block: got %b expected 0000", {m_aw_valid, s_aw_ready, m_ar_valid, s_ar_ready});
        else n_pass++;
        b_valid = 1; b_ready = 1;
        repeat (3) tick();
        b_valid = 0; b_ready = 0;
        n_total++;
        if (wr_cnt !== 8'd0 || drained !== 1'b0)
            $display("FAIL drain_wr_done: got wr=%0d drained=%b expected 0/0", wr_cnt, drained);
        else n_pass++;
        r_valid = 1; r_ready = 1; r_last = 1;
        tick();
        r_valid = 0; r_ready = 0; r_last = 0;
        n_total++;
        if (rd_cnt !== 8'd0 || drained !== 1'b0)
            $display("FAIL drain_rd_done: got rd=%0d drained=%b expected 0/0", rd_cnt, drained);
        else n_pass++;
        tick();
        n_total++;
        if (drained !== 1'b1 || m_aw_valid !== 1'b0)
            $display("FAIL drained_set: got drained=%b aw=%b expected 1/0", drained, m_aw_valid);
        else n_pass++;
        drain_req = 0;
        tick();
        #1;
        n_total++;
        if (drained !== 1'b0 || m_aw_valid !== 1'b1)
            $display("FAIL drain_resume: got drained=%b aw=%b expected 0/1", drained, m_aw_valid);
        else n_pass++;
        s_ar_valid = 0;
        tick();
        s_aw_valid = 0;
        n_total++;
        if (wr_cnt !== 8'd1) $display("FAIL drain_resume_cnt: got %0d expected 1", wr_cnt);
        else n_pass++;
    endtask

    task automatic test_underflow();
        go_run();
        b_valid = 1; b_ready = 1;
        tick();
        b_valid = 0; b_ready = 0;
        n_total++;
        if (err !== 2'b01 || wr_cnt !== 8'd0)
            $display("FAIL uf_write: got err=%b wr=%0d expected 01/0", err, wr_cnt);
        else n_pass++;
        s_aw_valid = 1; m_aw_ready = 1;
        tick();
        tick();
        s_aw_valid = 0;
        b_valid = 1; b_ready = 1;
        tick();
        b_valid = 0; b_ready = 0;
        n_total++;
        if (err !== 2'b01 || wr_cnt !== 8'd1)
            $display("FAIL uf_sticky: got err=%b wr=%0d expected 01/1", err, wr_cnt);
        else n_pass++;
        go_run();
        r_valid = 1; r_ready = 1; r_last = 1;
        tick();
        r_valid = 0; r_ready = 0; r_last = 0;
        n_total++;
        if (err !== 2'b01 || rd_cnt !== 8'd0)
            $display("FAIL uf_read: got err=%b rd=%0d expected 01/0", err, rd_cnt);
        else n_pass++;
    endtask

    task automatic test_calib_loss();
        go_run();
        s_aw_valid = 1; m_aw_ready = 1;
        tick();
        tick();
        s_aw_valid = 0;
        calib_done = 0;
        tick();
        s_aw_valid = 1;
        #1;
        n_total++;
        if (err !== 2'b10 || m_aw_valid !== 1'b0 || wr_cnt !== 8'd2)
            $display("FAIL calib_lost: got err=%b aw=%b wr=%0d expected 10/0/2", err, m_aw_valid, wr_cnt);
        else n_pass++;
        b_valid = 1; b_ready = 1;
        tick();
        tick();
        b_valid = 0; b_ready = 0;
        n_total++;
        if (wr_cnt !== 8'd0 || err !== 2'b10)
            $display("FAIL calib_lost_drain: got wr=%0d err=%b expected 0/10", wr_cnt, err);
        else n_pass++;
        calib_done = 1;
        tick();
        #1;
        n_total++;
        if (m_aw_valid !== 1'b1 || err !== 2'b10)
            $display("FAIL calib_regain: got aw=%b err=%b expected 1/10", m_aw_valid, err);
        else n_pass++;
        tick();
        s_aw_valid = 0;
    endtask

    task automatic test_random();
        logic [22:0] got, exp;
        bit aw_ok, ar_ok;
        int bad;
        go_run();
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            calib_done = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 99) < 3) drain_req = ~drain_req;
            s_aw_valid = $urandom_range(0, 1) == 1;
            m_aw_ready = $urandom_range(0, 3) != 0;
            s_ar_valid = $urandom_range(0, 1) == 1;
            m_ar_ready = $urandom_range(0, 3) != 0;
            b_valid    = (mw > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            b_ready    = $urandom_range(0, 3) != 0;
            r_valid    = (mr > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
            r_ready    = $urandom_range(0, 3) != 0;
            r_last     = $urandom_range(0, 9) < 4;
            #1;
            aw_ok = (ph == P_RUN) && (mw < MAX_WR);
            ar_ok = (ph == P_RUN) && (mr < MAX_RD);
            exp = {s_aw_valid && aw_ok, m_aw_ready && aw_ok, s_ar_valid && ar_ok, m_ar_ready && ar_ok,
                   ph == P_DRAINED, me1, me0, 8'(mw), 8'(mr)};
            got = {m_aw_valid, s_aw_ready, m_ar_valid, s_ar_ready, drained, err, wr_cnt, rd_cnt};
            n_total++;
            if (got !== exp) begin
                bad++;
                if (bad <= 5) $display("FAIL random_cycle_%0d: got %h expected %h", i, got, exp);
            end else n_pass++;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        calib_done = 0;
        idle_inputs();
        mw = 0; mr = 0; ph = P_CALIB; me0 = 0; me1 = 0;
        test_reset();
        test_calib_gate();
        test_write_cap();
        test_read_overlap();
        test_drain();
        test_underflow();
        test_calib_loss();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/noc_axi4_txn_gate.md
Name: noc_axi4_txn_gate

Overview:
- Sits on the mc_clk side, between the NoC-to-AXI4 bridge master port and the DDR4 controller AXI4 slave port.
- Gates AW/AR address handshakes until memory calibration completes and caps outstanding writes and reads.
- Provides a drain handshake so the chipset can quiesce memory traffic before reset or reconfiguration.
- Payloads, W, B and R are wired straight through at the top level. This block only touches AW/AR valid/ready and observes B/R handshakes.

Parameters:
MAX_WR, 16, max outstanding write bursts (AW accepted, B not yet received); 1..255
MAX_RD, 16, max outstanding read bursts (AR accepted, last R beat not yet received); 1..255

Ports:
clk  in  1  memory-controller UI clock
rst  in  1  synchronous, active-high reset
calib_done  in  1  DDR4 init calibration complete (already in clk domain)
drain_req  in  1  level; request to stop accepting new AW/AR
drained  out  1  high while in DRAINED state
wr_cnt  out  8  outstanding write bursts
rd_cnt  out  8  outstanding read bursts
err  out  2  sticky; [0] response underflow, [1] calib lost after RUN
s_aw_valid  in  1  from bridge
s_aw_ready  out  1  to bridge
m_aw_valid  out  1  to controller
m_aw_ready  in  1  from controller
s_ar_valid  in  1  from bridge
s_ar_ready  out  1  to bridge
m_ar_valid  out  1  to controller
m_ar_ready  in  1  from controller
b_valid  in  1  observed B valid
b_ready  in  1  observed B ready
r_valid  in  1  observed R valid
r_ready  in  1  observed R ready
r_last  in  1  observed R last

Behaviour:
- States: CALIB (reset state), RUN, DRAIN, DRAINED. State is registered.
- Transitions:
  - CALIB->RUN when calib_done=1.
  - RUN->DRAIN when drain_req=1.
  - DRAIN->DRAINED when wr_cnt=0, rd_cnt=0 and no AW/AR handshake this cycle.
  - DRAINED->RUN when drain_req=0.
  - Any non-CALIB state->CALIB when calib_done=0; set err[1].
  - drain_req held in CALIB: go CALIB->DRAIN on calib_done.
- aw_ok = (state==RUN) & (wr_cnt<MAX_WR), from registered values only.
  - m_aw_valid = s_aw_valid & aw_ok; s_aw_ready = m_aw_ready & aw_ok. Zero latency, no added valid->ready path.
- ar_ok = (state==RUN) & (rd_cnt<MAX_RD). AR gating mirrors AW.
- Write handshake (AW) = m_aw_valid & m_aw_ready; B handshake = b_valid & b_ready.
- Read handshake (AR) = m_ar_valid & m_ar_ready; read completion = r_valid & r_ready & r_last.
- wr_cnt: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle.
  - rd_cnt follows the same rule with AR handshake and read completion.
  - Counters are 8-bit unsigned; parameter bound guarantees no overflow.
- Underflow: a B handshake with wr_cnt=0 (AW not in same cycle) holds wr_cnt at 0 and sets err[0]. Same rule for R completion with rd_cnt=0.
- Once at the cap, the count must drop below MAX before the next AW/AR can handshake; a cap-freed slot is usable the following cycle.
- Non-last R beats do not change rd_cnt.
- Reset values: state CALIB; wr_cnt=rd_cnt=0; err=0; drained=0; m_aw_valid, m_ar_valid, s_aw_ready, s_ar_ready all 0.
  - rst must be asserted together with the controller reset. Responses to pre-reset bursts arriving afterwards set err[0].
- err bits clear only on rst.
- Calib loss mid-operation: counters keep tracking, so in-flight bursts still complete and decrement.

Decomposition:
- Package noc_axi4_txn_gate_pkg holds the state enum (CALIB/RUN/DRAIN/DRAINED), CNT_W=8, and err bit index constants.
- One sub-module, noc_axi4_txn_cnt (up/down counter with cap compare and underflow detect), instantiated twice (write, read).

Test Plan:
1. calib_done=0, s_aw_valid=1, m_aw_ready=1 for 20 cycles -> m_aw_valid=0, s_aw_ready=0, wr_cnt=0. Raise calib_done -> first AW handshake exactly 1 cycle later.
2. MAX_WR=4, m_aw_ready=1, no B -> 4 handshakes, wr_cnt=4, then m_aw_valid=0. One B handshake -> wr_cnt=3, next AW accepted the following cycle.
3. AR handshake and a read-completion beat in the same cycle with rd_cnt=2 -> rd_cnt stays 2. Non-last R beats leave rd_cnt unchanged.
4. wr_cnt=3, rd_cnt=1, assert drain_req:
   - AW/AR blocked immediately.
   - After the 3 B responses and the last R, drained=1 at the cycle after the count reaches 0.
   - Drop drain_req -> RUN and AW accepted again.
5. B handshake with wr_cnt=0 -> err=2'b01, wr_cnt stays 0. Further traffic runs normally and err stays set until rst.
6. In RUN with wr_cnt=2, drop calib_done -> err[1]=1, AW blocked, 2 B responses bring wr_cnt to 0. Re-raise calib_done -> RUN.
